block_serializer_fifo: RTL and testbench

- Accepts one wide cipher block per handshake and serialises it into bytes.
- Writes the bytes one per cycle into an internal parametrised FIFO, stalling on backpressure.
- Sits between the AES core output and the USB transmit path; the USB side drains bytes with r_enable.
- Adds valid/ready block handshake, selectable byte order, full-flow control and a FIFO occupancy count.

---
 rtl/blkser_pkg.sv | 22 ++
 rtl/block_serializer_fifo_if.sv | 43 ++++
 rtl/blkser_fifo.sv | 60 ++++++
 rtl/block_serializer_fifo.sv | 118 +++++++++++
 tb/tb_block_serializer_fifo.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/blkser_pkg.sv
// Shared types and helpers for the block serialiser: FSM states, byte width,
// and the byte-offset selection used to pick the next serialised byte.
package blkser_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE,
    SERIAL
  } state_t;

  // LSB position of the byte emitted at position idx of a block of n_bytes
  function automatic int unsigned byte_lsb(input int unsigned idx,
                                           input logic msb_first,
                                           input int unsigned n_bytes);
    if (msb_first) begin
      return BYTE_W * (n_bytes - 1 - idx);
    end
    return BYTE_W * idx;
  endfunction

endpackage

// File: rtl/block_serializer_fifo_if.sv
// Block-input handshake plus byte-output FIFO read side of the serialiser.
// r_last exists only when BLKSER_LAST_TAG_EN is defined.
interface block_serializer_fifo_if
  import blkser_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int FIFO_DEPTH  = 32
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                            blk_valid;
  logic                            blk_ready;
  logic [BYTE_W*BLOCK_BYTES-1:0]   blk_data;
  logic                            msb_first;
  logic                            r_enable;
  logic [BYTE_W-1:0]               r_data;
  logic                            empty;
  logic                            full;
  logic [CNT_W-1:0]                count;
  logic                            busy;
`ifdef BLKSER_LAST_TAG_EN
  logic                            r_last;

  modport master (
    output blk_valid, blk_data, msb_first, r_enable,
    input  blk_ready, r_data, empty, full, count, busy, r_last
  );
  modport slave (
    input  blk_valid, blk_data, msb_first, r_enable,
    output blk_ready, r_data, empty, full, count, busy, r_last
  );
`else
  modport master (
    output blk_valid, blk_data, msb_first, r_enable,
    input  blk_ready, r_data, empty, full, count, busy
  );
  modport slave (
    input  blk_valid, blk_data, msb_first, r_enable,
    output blk_ready, r_data, empty, full, count, busy
  );
`endif

endinterface

// File: rtl/blkser_fifo.sv
// First-word fall-through FIFO with separate occupancy counter; a write is
// accepted when full only if a read happens on the same edge.
module blkser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              do_rd;
  logic              do_wr;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (ADDR_W+1)'(DEPTH));
  assign count   = count_reg;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/block_serializer_fifo.sv
// Captures a wide block on handshake and writes its bytes one per cycle into a
// FWFT FIFO. Define BLKSER_LAST_TAG_EN to tag each block's final byte (r_last).
module block_serializer_fifo
  import blkser_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  block_serializer_fifo_if.slave  bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W  = $clog2(BLOCK_BYTES);
  localparam int BLK_W  = BYTE_W * BLOCK_BYTES;
`ifdef BLKSER_LAST_TAG_EN
  localparam int ENTRY_W = BYTE_W + 1;
`else
  localparam int ENTRY_W = BYTE_W;
`endif

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [BLK_W-1:0]  held_reg, held_next;
  logic              msb_reg, msb_next;

  logic              wr_en;
  logic              blk_ready;
  logic              busy;
  logic [BYTE_W-1:0] sel_byte;
  logic              last_byte;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W:0]   fifo_count;

  assign sel_byte  = held_reg[byte_lsb(32'(idx_reg), msb_reg, BLOCK_BYTES) +: BYTE_W];
  assign last_byte = (idx_reg == IDX_W'(BLOCK_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      held_reg  <= '0;
      msb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      held_reg  <= held_next;
      msb_reg   <= msb_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    held_next  = held_reg;
    msb_next   = msb_reg;
    wr_en      = 1'b0;
    blk_ready  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        blk_ready = 1'b1;
        if (bus.blk_valid) begin
          held_next  = bus.blk_data;
          msb_next   = bus.msb_first;
          idx_next   = '0;
          state_next = SERIAL;
        end
      end
      SERIAL: begin
        busy = 1'b1;
        // A pop on the same edge frees the slot even when the FIFO is full
        if (!fifo_full || (bus.r_enable && !fifo_empty)) begin
          wr_en    = 1'b1;
          idx_next = idx_reg + IDX_W'(1);
          if (last_byte) begin
            idx_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BLKSER_LAST_TAG_EN
  assign wr_entry   = {last_byte, sel_byte};
  assign bus.r_last = rd_entry[BYTE_W] && !fifo_empty;
`else
  assign wr_entry   = sel_byte;
`endif

  blkser_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (bus.r_enable),
    .rd_data (rd_entry),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.r_data    = rd_entry[BYTE_W-1:0];
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.count     = fifo_count;
  assign bus.blk_ready = blk_ready;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_block_serializer_fifo.sv
// Self-checking bench: byte streams are predicted from each accepted block by a
// queue model and compared against bytes actually popped from the FIFO.
module tb_block_serializer_fifo;
  localparam int BB    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  block_serializer_fifo_if #(.BLOCK_BYTES(BB), .FIFO_DEPTH(DEPTH)) bus ();

  block_serializer_fifo #(.BLOCK_BYTES(BB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit accepted;
  logic [7:0] exp_q[$];
  logic [7:0] pop_q[$];
`ifdef BLKSER_LAST_TAG_EN
  bit exp_last_q[$];
  bit pop_last_q[$];
`endif

  // Advance one clock, recording pops and accepted blocks seen at that edge
  task automatic step;
    accepted = 1'b0;
    if (n_rst && bus.r_enable && !bus.empty) begin
      pop_q.push_back(bus.r_data);
`ifdef BLKSER_LAST_TAG_EN
      pop_last_q.push_back(bus.r_last);
`endif
    end
    if (n_rst && bus.blk_valid && bus.blk_ready) begin
      accepted = 1'b1;
      $display("accept block=%h msb_first=%0b", bus.blk_data, bus.msb_first);
      for (int i = 0; i < BB; i++) begin
        int k;
        k = bus.msb_first ? (BB - 1 - i) : i;
        exp_q.push_back(bus.blk_data[8*k +: 8]);
`ifdef BLKSER_LAST_TAG_EN
        exp_last_q.push_back(i == BB - 1);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    exp_q.delete();
    pop_q.delete();
`ifdef BLKSER_LAST_TAG_EN
    exp_last_q.delete();
    pop_last_q.delete();
`endif
  endtask

  task automatic do_reset;
    bus.blk_valid = 1'b0;
    bus.r_enable  = 1'b0;
    n_rst = 1'b0;
    step;
    step;
    n_rst = 1'b1;
    clear_model;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.full); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.blk_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.blk_ready); end
`ifdef BLKSER_LAST_TAG_EN
    total++; if (bus.r_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b want=0", bus.r_last); end
`endif
  endtask

  task automatic test_order(input bit msb);
    logic [8*BB-1:0] d;
    logic [7:0] first;
    int low_cnt, busy_cnt;
    do_reset;
    for (int i = 0; i < BB; i++) d[8*i +: 8] = 8'(8'hA0 + i);
    first = msb ? 8'hAF : 8'hA0;
    bus.r_enable  = 1'b1;
    bus.msb_first = msb;
    bus.blk_data  = d;
    bus.blk_valid = 1'b1;
    step;
    bus.blk_valid = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.blk_ready) low_cnt++;
      if (bus.busy) busy_cnt++;
      step;
    end
    bus.r_enable = 1'b0;
    total++; if (low_cnt != BB) begin bad++; $display("FAIL order%0b_ready_low got=%0d want=%0d", msb, low_cnt, BB); end
    total++; if (busy_cnt != BB) begin bad++; $display("FAIL order%0b_busy got=%0d want=%0d", msb, busy_cnt, BB); end
    total++; if (pop_q.size() != BB) begin bad++; $display("FAIL order%0b_len got=%0d want=%0d", msb, pop_q.size(), BB); end
    if (pop_q.size() > 0) begin
      total++; if (pop_q[0] !== first) begin bad++; $display("FAIL order%0b_first got=%h want=%h", msb, pop_q[0], first); end
    end
    for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
      total++; if (pop_q[i] !== exp_q[i]) begin bad++; $display("FAIL order%0b_byte%0d got=%h want=%h", msb, i, pop_q[i], exp_q[i]); end
`ifdef BLKSER_LAST_TAG_EN
      total++; if (pop_last_q[i] !== exp_last_q[i]) begin bad++; $display("FAIL order%0b_last%0d got=%0b want=%0b", msb, i, pop_last_q[i], exp_last_q[i]); end
`endif
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    bus.r_enable  = 1'b0;
    bus.msb_first = 1'($urandom);
    bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_valid = 1'b1;
    step;
    bus.blk_valid = 1'b0;
    repeat (BB + 1) step;
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL bp_full got=%0b want=1", bus.full); end
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL bp_count got=%0d want=16", bus.count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%0b want=0", bus.busy); end
    bus.msb_first = 1'($urandom);
    bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_valid = 1'b1;
    step;
    bus.blk_valid = 1'b0;
    repeat (3) step;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bp_stall_busy got=%0b want=1", bus.busy); end
    total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%0b want=0", bus.blk_ready); end
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL bp_stall_count got=%0d want=16", bus.count); end
    bus.r_enable = 1'b1;
    step;
    bus.r_enable = 1'b0;
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL bp_one_count got=%0d want=16", bus.count); end
    total++; if (pop_q.size() != 1) begin bad++; $display("FAIL bp_one_pops got=%0d want=1", pop_q.size()); end
    repeat (2) step;
    total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL bp_hold_count got=%0d want=16", bus.count); end
  endtask

  // Continues from the full FIFO left by test_backpressure
  task automatic test_full_rw;
    bit done;
    bus.r_enable = 1'b1;
    for (int c = 0; c < BB - 1; c++) begin
      step;
      total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL frw_count cycle=%0d got=%0d want=16", c, bus.count); end
    end
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step;
      done = bus.empty && !bus.busy;
    end
    bus.r_enable = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL frw_drain got=not_drained want=drained"); end
    total++; if (pop_q.size() != 2*BB) begin bad++; $display("FAIL frw_len got=%0d want=%0d", pop_q.size(), 2*BB); end
    for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
      total++; if (pop_q[i] !== exp_q[i]) begin bad++; $display("FAIL frw_byte%0d got=%h want=%h", i, pop_q[i], exp_q[i]); end
`ifdef BLKSER_LAST_TAG_EN
      total++; if (pop_last_q[i] !== exp_last_q[i]) begin bad++; $display("FAIL frw_last%0d got=%0b want=%0b", i, pop_last_q[i], exp_last_q[i]); end
`endif
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.r_enable  = 1'b0;
    bus.msb_first = 1'b0;
    bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_valid = 1'b1;
    step;
    bus.blk_valid = 1'b0;
    repeat (5) step;
    n_rst = 1'b0;
    step;
    n_rst = 1'b1;
    clear_model;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%0b want=1", bus.empty); end
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", bus.count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", bus.busy); end
    total++; if (bus.blk_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b want=1", bus.blk_ready); end
    bus.r_enable = 1'b1;
    repeat (3) step;
    bus.r_enable = 1'b0;
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL empty_read_count got=%0d want=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL empty_read_empty got=%0b want=1", bus.empty); end
    total++; if (pop_q.size() != 0) begin bad++; $display("FAIL empty_read_pops got=%0d want=0", pop_q.size()); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL empty_read_busy got=%0b want=0", bus.busy); end
  endtask

  task automatic test_random;
    int sent;
    bit done;
    do_reset;
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      bus.r_enable = ($urandom_range(0, 9) < 7);
      if (!bus.blk_valid) begin
        bus.blk_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.msb_first = 1'($urandom);
        if (sent < 10 && $urandom_range(0, 3) == 0) bus.blk_valid = 1'b1;
      end
      step;
      if (accepted) begin
        bus.blk_valid = 1'b0;
        sent++;
      end
      total++; if (bus.full !== (bus.count == 5'd16)) begin bad++; $display("FAIL rnd_full cycle=%0d got=%0b count=%0d", c, bus.full, bus.count); end
      total++; if (bus.empty !== (bus.count == 5'd0)) begin bad++; $display("FAIL rnd_empty cycle=%0d got=%0b count=%0d", c, bus.empty, bus.count); end
      total++; if (bus.busy !== !bus.blk_ready) begin bad++; $display("FAIL rnd_busy cycle=%0d got=%0b want=%0b", c, bus.busy, !bus.blk_ready); end
      done = (sent == 10) && !bus.busy && bus.empty && !bus.blk_valid;
    end
    bus.r_enable = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL rnd_timeout got=sent%0d want=sent10_drained", sent); end
    total++; if (pop_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_len got=%0d want=%0d", pop_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
      total++; if (pop_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_byte%0d got=%h want=%h", i, pop_q[i], exp_q[i]); end
`ifdef BLKSER_LAST_TAG_EN
      total++; if (pop_last_q[i] !== exp_last_q[i]) begin bad++; $display("FAIL rnd_last%0d got=%0b want=%0b", i, pop_last_q[i], exp_last_q[i]); end
`endif
    end
  endtask

  initial begin
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.msb_first = 1'b0;
    bus.r_enable  = 1'b0;
    test_reset;
    test_order(1'b0);
    test_order(1'b1);
    test_backpressure;
    test_full_rw;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
